haz_scoreboard: RTL and testbench
=================================

# haz_scoreboard

Parametrised hazard and forwarding unit for the pipelined core. It replaces single-cycle load-use detection with a per-register latency scoreboard and supports N source operands and N forwarding stages. It also drives a multi-cycle branch flush, freezes on memory wait, and keeps a stall performance counter. It sits beside decode and drives the operand forwarding muxes, the FE/DE stall, and the FE/DE flush.

## Interface
Parameters:
- NUM_SRC, 2, source operands checked per decoded instruction
- NUM_STG, 2, forwarding stages; index 0 is nearest to decode (MEM), then WB, and so on
- MAX_LAT, 4, largest producer latency in cycles
- FLUSH_CYC, 2, cycles FLUSH stays high per taken branch
- CNT_W, 32, stall counter width

Ports:
- CLK  in  1  core clock; all state updates on the rising edge
- RST_N  in  1  synchronous, active-low reset
- DE_VALID  in  1  decode holds a valid instruction
- DE_RS  in  NUM_SRC*5  source register addresses; operand k is at [5k+4:5k]
- DE_RS_USED  in  NUM_SRC  operand k is actually read
- DE_RD  in  5  destination register of the decode instruction
- DE_WE  in  1  decode instruction writes DE_RD
- DE_LAT  in  $clog2(MAX_LAT+1)  cycles from issue until the result is forwardable (ALU 1, load 2)
- STG_RD  in  NUM_STG*5  destination register per stage
- STG_WE  in  NUM_STG  stage i writes STG_RD[i]
- STG_FWD_OK  in  NUM_STG  stage i has its result on the forward bus
- BR_TAKEN  in  1  EX resolved a taken branch or jump
- MEM_BUSY  in  1  data memory wait; the pipeline is frozen
- FWD_SEL  out  NUM_SRC*SEL_W  per-operand mux select; 0 selects the regfile, i+1 selects stage i; SEL_W=$clog2(NUM_STG+1)
- STALL  out  1  hold FE and DE and insert a bubble into EX
- FLUSH  out  1  kill FE and DE
- STALL_CNT  out  CNT_W  count of data-hazard stall cycles

## Operation
- Scoreboard: cnt[1..31] hold the remaining cycles until each register's value is forwardable. x0 has no entry and never hazards.
- issue = DE_VALID & ~STALL & ~FLUSH & ~MEM_BUSY.
- On issue with DE_WE and DE_RD≠0, cnt[DE_RD] <= max(DE_LAT,1)-1. DE_LAT=0 is treated as 1. DE_LAT>MAX_LAT is clamped to MAX_LAT.
- When MEM_BUSY=0, every other non-zero cnt decrements by 1 each cycle. An issue write to a register overrides its decrement in the same cycle.
- When MEM_BUSY=1, all cnt, the flush counter and STALL_CNT hold.
- Data hazard: operand k hazards when DE_VALID & DE_RS_USED[k] & rs_k≠0 & cnt[rs_k]≠0.
- STALL = (any data hazard & ~FLUSH) | MEM_BUSY.
- Forwarding: FWD_SEL[k] = i+1 for the lowest i with STG_WE[i] & STG_FWD_OK[i] & STG_RD[i]==rs_k≠0. Otherwise FWD_SEL[k]=0. The nearest stage wins.
- Flush FSM states:
  - IDLE: FLUSH=0.
  - FLUSHING: down-counter fc from FLUSH_CYC-1 to 0, with FLUSH=1.
- Flush transitions:
  - BR_TAKEN & ~MEM_BUSY moves to FLUSHING with fc=FLUSH_CYC-1.
  - In FLUSHING, a new BR_TAKEN reloads fc.
  - fc=0 with no BR_TAKEN returns to IDLE.
  - BR_TAKEN is ignored while MEM_BUSY=1; upstream holds it.
- STALL_CNT increments on each cycle with a data hazard, STALL=1 and MEM_BUSY=0. It saturates at all-ones.

## Timing
- Reset (RST_N=0 at an edge) clears all cnt to 0, sets the flush FSM to IDLE, and sets STALL_CNT to 0.
- From the cycle after reset: FLUSH=0, STALL=MEM_BUSY, FWD_SEL follows the inputs combinationally.
- A reset asserted mid-flush or mid-stall clears state on that edge.
- STALL and FWD_SEL are combinational from registered state plus inputs, with zero latency.
- FLUSH is registered and goes high in the cycle after BR_TAKEN is sampled.
- Load (LAT 2) issued in cycle t, consumer in DE at t+1: STALL=1 at t+1. The consumer issues at t+2, where FWD_SEL selects the WB stage.
- ALU op (LAT 1): no stall; the next cycle selects stage 0.

## Structure
- Package haz_pkg holds:
  - constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=3
  - flush state enum {IDLE, FLUSHING}
  - function sel_w(n) returning $clog2(n+1)
- Sub-module haz_fwd_prio: one operand's priority encoder over NUM_STG stages, instantiated NUM_SRC times by a generate loop.

## Test plan
- Load x5 (LAT 2) issues, then add x6,x5,x1 in DE: STALL=1 for one cycle, STALL_CNT=1. The next cycle gives STALL=0 and FWD_SEL[0]=2.
- Back-to-back ALU writes to x7 with STG_RD={x7,x7} both FWD_OK, consumer reads x7: FWD_SEL=1 (nearest stage), no stall.
- mul x3 (LAT 4) followed by a dependent instruction: exactly 3 stall cycles. With MEM_BUSY=1 for 2 cycles mid-wait, the count stays 3, but STALL lasts 5 cycles.
- BR_TAKEN pulse with FLUSH_CYC=2: FLUSH high for 2 cycles starting the next cycle. A second BR_TAKEN in the first flush cycle extends FLUSH to 3 cycles total.
- Operand x0, or DE_RS_USED=0 with cnt set on that register: no stall, FWD_SEL=0. Issue with DE_RD=0 leaves all cnt at 0.
- RST_N low for one edge while cnt[9]=2 and FLUSHING: afterwards no stall on x9, FLUSH=0, STALL_CNT=0.

Source files
------------

// File: rtl/haz_pkg.sv
// haz_pkg: shared definitions for the hazard/forwarding scoreboard.
//   LAT_*          nominal producer latencies (cycles until forwardable)
//   flush_state_e  state encoding of the branch flush FSM
//   sel_w(n)       width of a forwarding mux select covering regfile + n stages
package haz_pkg;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 3;

    typedef enum logic {
        IDLE,
        FLUSHING
    } flush_state_e;

    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/haz_fwd_prio.sv
// haz_fwd_prio: forwarding priority encoder for one source operand.
// Ports:
//   rs          source register address of the operand
//   stg_rd      destination register per forwarding stage, stage i at [5i+4:5i]
//   stg_we      stage i writes stg_rd[i]
//   stg_fwd_ok  stage i has its result on the forward bus
//   sel         0 = regfile, i+1 = stage i; the lowest (nearest) stage wins
module haz_fwd_prio
    import haz_pkg::*;
#(
    parameter int NUM_STG = 2
) (
    input  logic [4:0]                 rs,
    input  logic [NUM_STG*5-1:0]       stg_rd,
    input  logic [NUM_STG-1:0]         stg_we,
    input  logic [NUM_STG-1:0]         stg_fwd_ok,
    output logic [sel_w(NUM_STG)-1:0]  sel
);

    localparam int SEL_W = sel_w(NUM_STG);

    // Scan from the farthest stage down so the nearest match overwrites.
    always_comb begin
        sel = '0;
        if (rs != 5'd0) begin
            for (int i = NUM_STG - 1; i >= 0; i--) begin
                if (stg_we[i] && stg_fwd_ok[i] && (stg_rd[5*i +: 5] == rs)) begin
                    sel = SEL_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/haz_scoreboard.sv
// haz_scoreboard: per-register latency scoreboard, operand forwarding select,
// decode stall, multi-cycle branch flush and data-hazard stall counter.
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   DE_VALID          decode holds a valid instruction
//   DE_RS/DE_RS_USED  source register addresses (5 bits each) and read enables
//   DE_RD/DE_WE       destination register and write enable of decode
//   DE_LAT            cycles from issue until the result is forwardable
//   STG_RD/STG_WE/STG_FWD_OK  per forwarding stage destination/write/ready
//   BR_TAKEN          taken branch resolved in EX
//   MEM_BUSY          data memory wait, whole pipeline frozen
//   FWD_SEL           per-operand forward mux select (0 = regfile, i+1 = stage i)
//   STALL             hold FE/DE and bubble EX
//   FLUSH             kill FE/DE
//   STALL_CNT         saturating count of data-hazard stall cycles
module haz_scoreboard
    import haz_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int NUM_STG   = 2,
    parameter int MAX_LAT   = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              DE_VALID,
    input  logic [NUM_SRC*5-1:0]              DE_RS,
    input  logic [NUM_SRC-1:0]                DE_RS_USED,
    input  logic [4:0]                        DE_RD,
    input  logic                              DE_WE,
    input  logic [$clog2(MAX_LAT+1)-1:0]      DE_LAT,
    input  logic [NUM_STG*5-1:0]              STG_RD,
    input  logic [NUM_STG-1:0]                STG_WE,
    input  logic [NUM_STG-1:0]                STG_FWD_OK,
    input  logic                              BR_TAKEN,
    input  logic                              MEM_BUSY,
    output logic [NUM_SRC*sel_w(NUM_STG)-1:0] FWD_SEL,
    output logic                              STALL,
    output logic                              FLUSH,
    output logic [CNT_W-1:0]                  STALL_CNT
);

    localparam int SEL_W = sel_w(NUM_STG);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [FC_W-1:0]  FC_LOAD   = FC_W'(FLUSH_CYC - 1);
    localparam logic [LAT_W-1:0] LAT_MAX_V = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_MIN_V = LAT_W'(LAT_ALU);

    logic [LAT_W-1:0]  cnt [1:31];
    logic [31:0]       busy;
    logic [NUM_SRC-1:0] haz;
    logic              any_haz;
    logic              issue;
    logic [LAT_W-1:0]  lat_eff;
    logic [LAT_W-1:0]  cnt_load;

    flush_state_e      state_q;
    flush_state_e      state_d;
    logic [FC_W-1:0]   fc_q;
    logic [FC_W-1:0]   fc_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    // Per-register "not yet forwardable" flags; bit 0 stays clear so x0
    // can never raise a hazard.
    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        haz = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            haz[k] = DE_VALID && DE_RS_USED[k] && busy[DE_RS[5*k +: 5]];
        end
    end

    assign any_haz = |haz;
    assign FLUSH   = (state_q == FLUSHING);
    assign STALL   = (any_haz && !FLUSH) || MEM_BUSY;
    assign issue   = DE_VALID && !STALL && !FLUSH && !MEM_BUSY;

    // Latency 0 behaves like a single-cycle ALU op; oversize values clamp.
    always_comb begin
        if (DE_LAT < LAT_MIN_V) begin
            lat_eff = LAT_MIN_V;
        end else if (DE_LAT > LAT_MAX_V) begin
            lat_eff = LAT_MAX_V;
        end else begin
            lat_eff = DE_LAT;
        end
        cnt_load = lat_eff - LAT_W'(1);
    end

    // Scoreboard: an issue write takes precedence over the decrement.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int r = 1; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else if (!MEM_BUSY) begin
            for (int r = 1; r < 32; r++) begin
                if (issue && DE_WE && (DE_RD == 5'(r))) begin
                    cnt[r] <= cnt_load;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // Flush FSM: register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    // Flush FSM: next state. Everything holds while memory is busy, which
    // also means a branch presented during the wait is not taken up.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        if (!MEM_BUSY) begin
            if (BR_TAKEN) begin
                state_d = FLUSHING;
                fc_d    = FC_LOAD;
            end else if (state_q == FLUSHING) begin
                if (fc_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fc_d = fc_q - FC_W'(1);
                end
            end
        end
    end

    // Only genuine data-hazard stalls are counted, not memory freezes.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
        end else if (any_haz && !FLUSH && !MEM_BUSY && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign STALL_CNT = stall_cnt_q;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        haz_fwd_prio #(
            .NUM_STG (NUM_STG)
        ) u_prio (
            .rs         (DE_RS[5*k +: 5]),
            .stg_rd     (STG_RD),
            .stg_we     (STG_WE),
            .stg_fwd_ok (STG_FWD_OK),
            .sel        (FWD_SEL[SEL_W*k +: SEL_W])
        );
    end

endmodule

// File: tb/tb_haz_scoreboard.sv
// tb_haz_scoreboard: directed, table-driven bench for haz_scoreboard with
// default parameters (2 operands, 2 stages, MAX_LAT 4, FLUSH_CYC 2).
module tb_haz_scoreboard;
    import haz_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        DE_VALID;
    logic [9:0]  DE_RS;
    logic [1:0]  DE_RS_USED;
    logic [4:0]  DE_RD;
    logic        DE_WE;
    logic [2:0]  DE_LAT;
    logic [9:0]  STG_RD;
    logic [1:0]  STG_WE;
    logic [1:0]  STG_FWD_OK;
    logic        BR_TAKEN;
    logic        MEM_BUSY;
    logic [3:0]  FWD_SEL;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] STALL_CNT;

    int tests  = 0;
    int failed = 0;

    haz_scoreboard dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DE_VALID   (DE_VALID),
        .DE_RS      (DE_RS),
        .DE_RS_USED (DE_RS_USED),
        .DE_RD      (DE_RD),
        .DE_WE      (DE_WE),
        .DE_LAT     (DE_LAT),
        .STG_RD     (STG_RD),
        .STG_WE     (STG_WE),
        .STG_FWD_OK (STG_FWD_OK),
        .BR_TAKEN   (BR_TAKEN),
        .MEM_BUSY   (MEM_BUSY),
        .FWD_SEL    (FWD_SEL),
        .STALL      (STALL),
        .FLUSH      (FLUSH),
        .STALL_CNT  (STALL_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  rs0, rs1;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  lat;
        logic [4:0]  srd0, srd1;
        logic [1:0]  swe, sok;
        logic        br, busy, rst_n;
        logic        e_stall, e_flush;
        logic [3:0]  e_sel;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic valid, logic [4:0] rs0, logic [4:0] rs1,
                                logic [1:0] used, logic [4:0] rd, logic we, int lat,
                                logic [4:0] srd0, logic [4:0] srd1, logic [1:0] swe,
                                logic [1:0] sok, logic br, logic busy, logic rst_n,
                                logic e_stall, logic e_flush, logic [3:0] e_sel,
                                logic [31:0] e_cnt);
        vec_t v;
        v.name = name; v.valid = valid; v.rs0 = rs0; v.rs1 = rs1; v.used = used;
        v.rd = rd; v.we = we; v.lat = 3'(lat); v.srd0 = srd0; v.srd1 = srd1;
        v.swe = swe; v.sok = sok; v.br = br; v.busy = busy; v.rst_n = rst_n;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_sel = e_sel; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RST_N      = v.rst_n;
        DE_VALID   = v.valid;
        DE_RS      = {v.rs1, v.rs0};
        DE_RS_USED = v.used;
        DE_RD      = v.rd;
        DE_WE      = v.we;
        DE_LAT     = v.lat;
        STG_RD     = {v.srd1, v.srd0};
        STG_WE     = v.swe;
        STG_FWD_OK = v.sok;
        BR_TAKEN   = v.br;
        MEM_BUSY   = v.busy;
    endtask

    task automatic cmp(input string name, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s.%s: got %0h, expected %0h", name, what, act, exp);
        end
    endtask

    // Drive one row, sample mid-cycle, then advance past the next rising edge.
    task automatic run_row(input vec_t v);
        drive(v);
        #4;
        cmp(v.name, "stall",     32'(STALL),     32'(v.e_stall));
        cmp(v.name, "flush",     32'(FLUSH),     32'(v.e_flush));
        cmp(v.name, "fwd_sel",   32'(FWD_SEL),   32'(v.e_sel));
        cmp(v.name, "stall_cnt", STALL_CNT,      v.e_cnt);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //           name              vld rs0 rs1 used  rd we lat       srd0 srd1 swe    sok    br bsy rn  stl fl sel   cnt
        vecs.push_back(mk("reset_state",    0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 0));
        vecs.push_back(mk("load_issue",     1, 1,  2, 2'b00, 5, 1, LAT_LOAD, 0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 0));
        vecs.push_back(mk("loaduse_stall",  1, 5,  1, 2'b11, 6, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 0));
        vecs.push_back(mk("loaduse_fwd_wb", 1, 5,  1, 2'b11, 6, 1, LAT_ALU,  0, 5, 2'b10, 2'b10, 0, 0, 1,  0, 0, 4'h2, 1));
        vecs.push_back(mk("alu_x7_a",       1, 0,  0, 2'b00, 7, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 1));
        vecs.push_back(mk("alu_x7_b",       1, 0,  0, 2'b00, 7, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 1));
        vecs.push_back(mk("fwd_nearest",    1, 7,  7, 2'b11, 8, 1, LAT_ALU,  7, 7, 2'b11, 2'b11, 0, 0, 1,  0, 0, 4'h5, 1));
        vecs.push_back(mk("fwd_ok_gate",    1, 7,  7, 2'b11, 8, 1, LAT_ALU,  7, 7, 2'b11, 2'b10, 0, 0, 1,  0, 0, 4'hA, 1));
        vecs.push_back(mk("mul_issue",      1, 0,  0, 2'b00, 3, 1, 4,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 1));
        vecs.push_back(mk("mul_stall1",     1, 3,  0, 2'b01,10, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 1));
        vecs.push_back(mk("mul_busy1",      1, 3,  0, 2'b01,10, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 1, 1,  1, 0, 4'h0, 2));
        vecs.push_back(mk("mul_busy2",      1, 3,  0, 2'b01,10, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 1, 1,  1, 0, 4'h0, 2));
        vecs.push_back(mk("mul_stall2",     1, 3,  0, 2'b01,10, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 2));
        vecs.push_back(mk("mul_stall3",     1, 3,  0, 2'b01,10, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 3));
        vecs.push_back(mk("mul_go",         1, 3,  0, 2'b01,10, 1, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 4));
        vecs.push_back(mk("set_x11",        1, 0,  0, 2'b00,11, 1, 4,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 4));
        vecs.push_back(mk("rs_x0",          1, 0,  0, 2'b11, 0, 0, LAT_ALU,  0, 0, 2'b01, 2'b01, 0, 0, 1,  0, 0, 4'h0, 4));
        vecs.push_back(mk("unused_x11",     1,11, 11, 2'b00, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 4));
        vecs.push_back(mk("used_x11",       1,11,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 4));
        vecs.push_back(mk("x11_clear",      1,11,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("rd0_issue",      1, 0,  0, 2'b00, 0, 1, 4,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("rd0_check",      1, 1, 31, 2'b11, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("br_pulse",       0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 1, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("flush_c1",       0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 1, 4'h0, 5));
        vecs.push_back(mk("flush_c2",       0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 1, 4'h0, 5));
        vecs.push_back(mk("flush_end",      0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("br_first",       0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 1, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("br_extend",      0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 1, 0, 1,  0, 1, 4'h0, 5));
        vecs.push_back(mk("ext_c2",         0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 1, 4'h0, 5));
        vecs.push_back(mk("ext_c3",         0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 1, 4'h0, 5));
        vecs.push_back(mk("ext_end",        0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("br_while_busy",  0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 1, 1, 1,  1, 0, 4'h0, 5));
        vecs.push_back(mk("br_ignored",     0, 0,  0, 2'b00, 0, 0, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("lat0_issue",     1, 0,  0, 2'b00,12, 1, 0,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("lat0_use",       1,12,  0, 2'b01,13, 1, 7,        0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 5));
        vecs.push_back(mk("lat7_s1",        1,13,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 5));
        vecs.push_back(mk("lat7_s2",        1,13,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 6));
        vecs.push_back(mk("lat7_s3",        1,13,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 7));
        vecs.push_back(mk("lat7_go",        1,13,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 8));
        vecs.push_back(mk("mask_set",       1, 0,  0, 2'b00,14, 1, 4,        0, 0, 2'b00, 2'b00, 1, 0, 1,  0, 0, 4'h0, 8));
        vecs.push_back(mk("mask_flush1",    1,14,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 1, 4'h0, 8));
        vecs.push_back(mk("mask_flush2",    1,14,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 1, 4'h0, 8));
        vecs.push_back(mk("mask_after",     1,14,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 8));
        vecs.push_back(mk("mask_clear",     1,14,  0, 2'b01, 0, 0, LAT_ALU,  0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 9));

        drive(mk("init", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        repeat (2) @(posedge CLK);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_row(vecs[i]);
        end

        // Reset landing in the middle of a flush with x9 still pending.
        run_row(mk("rst_prep",          1, 0, 0, 2'b00, 9, 1, 3,       0, 0, 2'b00, 2'b00, 1, 0, 1,  0, 0, 4'h0, 9));
        run_row(mk("rst_during_flush",  1, 9, 0, 2'b01, 0, 0, LAT_ALU, 0, 0, 2'b00, 2'b00, 0, 0, 0,  0, 1, 4'h0, 9));
        run_row(mk("post_rst_x9",       1, 9, 0, 2'b01, 0, 0, LAT_ALU, 0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 0));
        run_row(mk("post_rst_idle",     0, 0, 0, 2'b00, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 0, 4'h0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
